// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read controller.
// Holds the opcode, operand, address and instruction types plus the storage
// depth and the width of the occupancy counter.
package instr_register_pkg;

  localparam int DEPTH   = 32;
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [$clog2(DEPTH)-1:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

// File: rtl/instr_reg_ctrl_if.sv
// Bus between the two requesters / the consumer and instr_reg_ctrl.
//   req_*          : per-requester write request, payload and grant
//   load_en, opcode, operand_a/b, write_pointer : registered write port
//   rd_valid/rd_ready, read_pointer              : pop handshake
//   count, full, empty                           : occupancy status
// master = requester/consumer side, slave = controller side.
interface instr_reg_ctrl_if;
  import instr_register_pkg::*;

  logic [1:0]         req_valid;
  opcode_t  [1:0]     req_opcode;
  operand_t [1:0]     req_operand_a;
  operand_t [1:0]     req_operand_b;
  logic [1:0]         req_ready;
  logic               load_en;
  opcode_t            opcode;
  operand_t           operand_a;
  operand_t           operand_b;
  address_t           write_pointer;
  logic               rd_valid;
  logic               rd_ready;
  address_t           read_pointer;
  logic [COUNT_W-1:0] count;
  logic               full;
  logic               empty;

  modport master (
    output req_valid, req_opcode, req_operand_a, req_operand_b, rd_valid,
    input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
           rd_ready, read_pointer, count, full, empty
  );

  modport slave (
    input  req_valid, req_opcode, req_operand_a, req_operand_b, rd_valid,
    output req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
           rd_ready, read_pointer, count, full, empty
  );

endinterface

// File: rtl/instr_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request per requester
//   en         : grants allowed this cycle (low while full)
//   gnt[1:0]   : combinational one-hot grant
// The priority bit points at the requester that wins a tie; after any grant
// it moves to the requester that was not granted.
module instr_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic pri;

  always_comb begin
    gnt = 2'b00;
    // Reset gating keeps the grant low during the reset cycle itself.
    if (en && !reset) begin
      if (req == 2'b11) gnt = pri ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       pri <= 1'b0;
    else if (|gnt)   pri <= gnt[0];
  end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Write/read controller for the instruction register.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of instr_reg_ctrl_if (requests, write port,
//                pop handshake, occupancy flags)
// An accepted request is registered and presented on load_en/payload/
// write_pointer the following cycle; the pointers and count track the
// written-but-unpopped entries. Pointers wrap naturally at the width of
// address_t, so DEPTH must stay equal to 2**$bits(address_t).
module instr_reg_ctrl #(
  parameter int DEPTH = instr_register_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  instr_reg_ctrl_if.slave  bus
);
  import instr_register_pkg::*;

  logic [1:0]         gnt;
  logic               accept;
  logic               pop;
  address_t           wp;
  address_t           rp;
  logic [COUNT_W-1:0] cnt;

  instr_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req_valid),
    .en    (!bus.full),
    .gnt   (gnt)
  );

  assign accept            = |gnt;
  assign pop               = bus.rd_valid && bus.rd_ready;
  assign bus.req_ready     = gnt;
  // A pending load_en write already owns a slot, so it counts toward full.
  assign bus.full          = (cnt + COUNT_W'(bus.load_en)) == COUNT_W'(DEPTH);
  assign bus.empty         = (cnt == '0);
  assign bus.rd_ready      = !bus.empty;
  assign bus.count         = cnt;
  assign bus.write_pointer = wp;
  assign bus.read_pointer  = rp;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.load_en   <= 1'b0;
      bus.opcode    <= ZERO;
      bus.operand_a <= '0;
      bus.operand_b <= '0;
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
    end else begin
      bus.load_en <= accept;
      if (accept) begin
        if (gnt[1]) begin
          bus.opcode    <= bus.req_opcode[1];
          bus.operand_a <= bus.req_operand_a[1];
          bus.operand_b <= bus.req_operand_b[1];
        end else begin
          bus.opcode    <= bus.req_opcode[0];
          bus.operand_a <= bus.req_operand_a[0];
          bus.operand_b <= bus.req_operand_b[0];
        end
      end
      if (bus.load_en) wp <= wp + address_t'(1);
      if (pop)         rp <= rp + address_t'(1);
      case ({bus.load_en, pop})
        2'b10:   cnt <= cnt + COUNT_W'(1);
        2'b01:   cnt <= cnt - COUNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Directed bench for instr_reg_ctrl: hand-computed expectations for reset,
// single write, round-robin ties, fill to full, simultaneous write/pop with
// pointer wrap, pop while empty and reset over a pending write.
module tb_instr_reg_ctrl;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instr_reg_ctrl_if bus ();

  instr_reg_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are changed and outputs sampled 2 ns after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req_valid        = 2'b00;
    bus.rd_valid         = 1'b0;
    bus.req_opcode[0]    = ADD;
    bus.req_operand_a[0] = 32'sd5;
    bus.req_operand_b[0] = 32'sd3;
    bus.req_opcode[1]    = SUB;
    bus.req_operand_a[1] = 32'sd9;
    bus.req_operand_b[1] = 32'sd4;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    step();
    step();

    // Reset cycle: request present but must not be granted.
    bus.req_valid = 2'b01;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_load", 32'(bus.load_en), 32'd0);
    chk("rst_wp", 32'(bus.write_pointer), 32'd0);
    chk("rst_rp", 32'(bus.read_pointer), 32'd0);
    chk("rst_op", 32'(bus.opcode), 32'(ZERO));

    // Single ADD 5,3 from requester 0.
    reset = 1'b0;
    #1;
    chk("w1_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b00;
    #1;
    chk("w1_load", 32'(bus.load_en), 32'd1);
    chk("w1_op", 32'(bus.opcode), 32'(ADD));
    chk("w1_a", bus.operand_a, 32'd5);
    chk("w1_b", bus.operand_b, 32'd3);
    chk("w1_wp", 32'(bus.write_pointer), 32'd0);
    chk("w1_cnt_pend", 32'(bus.count), 32'd0);
    step();
    chk("w1_load_off", 32'(bus.load_en), 32'd0);
    chk("w1_count", 32'(bus.count), 32'd1);
    chk("w1_rdready", 32'(bus.rd_ready), 32'd1);
    chk("w1_rp", 32'(bus.read_pointer), 32'd0);
    chk("w1_op_hold", 32'(bus.opcode), 32'(ADD));
    chk("w1_wp_next", 32'(bus.write_pointer), 32'd1);

    // Round robin with both requesters valid for 4 cycles.
    do_reset();
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      chk("rr_load", 32'(bus.load_en), 32'd1);
      chk("rr_wp", 32'(bus.write_pointer), 32'(k));
      chk("rr_op", 32'(bus.opcode), (k % 2 == 0) ? 32'(ADD) : 32'(SUB));
    end
    bus.req_valid = 2'b00;
    step();
    chk("rr_count", 32'(bus.count), 32'd4);

    // Fill 32 entries from requester 1, no pops.
    do_reset();
    bus.req_valid = 2'b10;
    for (int c = 0; c < 32; c++) begin
      #1;
      chk("fill_gnt", 32'(bus.req_ready), 32'd2);
      step();
    end
    #1;
    chk("fill32_load", 32'(bus.load_en), 32'd1);
    chk("fill32_wp", 32'(bus.write_pointer), 32'd31);
    chk("fill32_full", 32'(bus.full), 32'd1);
    chk("fill32_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("full_count", 32'(bus.count), 32'd32);
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_load", 32'(bus.load_en), 32'd0);
    chk("full_wp_wrap", 32'(bus.write_pointer), 32'd0);
    bus.rd_valid = 1'b1;
    #1;
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.rd_valid = 1'b0;
    #1;
    chk("pop_count", 32'(bus.count), 32'd31);
    chk("pop_full", 32'(bus.full), 32'd0);
    chk("pop_rp", 32'(bus.read_pointer), 32'd1);
    chk("resume_gnt", 32'(bus.req_ready), 32'd2);
    step();
    chk("resume_load", 32'(bus.load_en), 32'd1);
    chk("resume_full", 32'(bus.full), 32'd1);

    // Steady state at count 5 with simultaneous write and pop.
    do_reset();
    bus.req_valid = 2'b01;
    for (int c = 0; c < 6; c++) step();
    bus.req_valid = 2'b00;
    bus.rd_valid  = 1'b1;
    #1;
    chk("ss_count", 32'(bus.count), 32'd5);
    chk("ss_load", 32'(bus.load_en), 32'd1);
    chk("ss_wp", 32'(bus.write_pointer), 32'd5);
    chk("ss_rp", 32'(bus.read_pointer), 32'd0);
    step();
    chk("ss_count_same", 32'(bus.count), 32'd5);
    chk("ss_wp_adv", 32'(bus.write_pointer), 32'd6);
    chk("ss_rp_adv", 32'(bus.read_pointer), 32'd1);

    // Stream writes and pops until the read pointer sits at 31.
    bus.req_valid = 2'b01;
    for (int c = 0; c < 30; c++) step();
    chk("wrap_rp31", 32'(bus.read_pointer), 32'd31);
    chk("wrap_count", 32'(bus.count), 32'd4);
    chk("wrap_load", 32'(bus.load_en), 32'd1);
    chk("wrap_wp", 32'(bus.write_pointer), 32'd3);
    bus.req_valid = 2'b00;
    step();
    chk("wrap_rp0", 32'(bus.read_pointer), 32'd0);
    chk("wrap_count_same", 32'(bus.count), 32'd4);
    chk("wrap_wp_adv", 32'(bus.write_pointer), 32'd4);

    // Drain, then pop while empty.
    for (int c = 0; c < 4; c++) step();
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_rdready", 32'(bus.rd_ready), 32'd0);
    chk("drain_rp", 32'(bus.read_pointer), 32'd4);
    step();
    step();
    chk("emp_pop_rp", 32'(bus.read_pointer), 32'd4);
    chk("emp_pop_count", 32'(bus.count), 32'd0);
    chk("emp_pop_empty", 32'(bus.empty), 32'd1);
    bus.rd_valid = 1'b0;

    // Reset while a write is pending; priority had moved to requester 1.
    do_reset();
    bus.req_valid = 2'b01;
    step();
    chk("rw_load", 32'(bus.load_en), 32'd1);
    reset = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("rw_rst_ready", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rw_load_off", 32'(bus.load_en), 32'd0);
    chk("rw_count", 32'(bus.count), 32'd0);
    chk("rw_wp", 32'(bus.write_pointer), 32'd0);
    chk("rw_rp", 32'(bus.read_pointer), 32'd0);
    chk("rw_pri", 32'(bus.req_ready), 32'd1);
    chk("rw_op", 32'(bus.opcode), 32'(ZERO));
    bus.req_valid = 2'b00;
    step();
    chk("rw_after_count", 32'(bus.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_reg_ctrl.md
INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter: DEPTH, default 32, number of entries in the instr_register storage; equals 2**$bits(address_t).
REQ-003 Ports, in this order:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester write request; bit i belongs to requester i.
- req_opcode  in  2 x opcode_t  per-requester opcode.
- req_operand_a  in  2 x operand_t  per-requester operand A.
- req_operand_b  in  2 x operand_t  per-requester operand B.
- req_ready  out  2  grant, combinational; at most one bit high per cycle.
- load_en  out  1  registered write strobe to instr_register.
- opcode  out  opcode_t  registered write opcode.
- operand_a  out  operand_t  registered write operand A.
- operand_b  out  operand_t  registered write operand B.
- write_pointer  out  address_t  registered write address.
- rd_valid  in  1  consumer pops the oldest entry.
- rd_ready  out  1  oldest entry is readable at read_pointer.
- read_pointer  out  address_t  address of the oldest written entry.
- count  out  $clog2(DEPTH)+1  number of written, unpopped entries.
- full  out  1  no further request can be granted.
- empty  out  1  count == 0.

Function
REQ-004 A transfer on requester i SHALL occur on a rising edge where req_valid[i] && req_ready[i]; the requester holds its payload stable until then.
REQ-005 req_ready SHALL be all-zero when full is 1.
REQ-006 When both requesters are valid and not full, req_ready SHALL go to the requester indicated by the round-robin priority bit.
REQ-007 The priority bit SHALL be 0 after reset and SHALL toggle to the other requester after each grant.
REQ-008 A lone valid requester SHALL be granted regardless of priority.
REQ-009 Write timing: accept at edge N -> load_en=1 with the captured payload and write_pointer=wp during cycle N+1 -> the entry is written at edge N+1.
REQ-010 Without an accept, load_en SHALL be 0 and the payload outputs SHALL hold their last value.
REQ-011 wp SHALL increment modulo DEPTH on each cycle where load_en=1; write_pointer SHALL show wp.
REQ-012 count SHALL increment at the edge ending a load_en=1 cycle and SHALL decrement on a pop.
- Pop condition: rd_valid && rd_ready.
- Both in the same cycle: count is unchanged.
REQ-013 full SHALL equal (count + load_en == DEPTH).
- This reserves the slot for a pending write.
- Back-to-back grants SHALL be sustained while not full, at 1 transfer per cycle.
REQ-014 rd_ready SHALL be !empty.
- rd_valid while empty SHALL be ignored: no pointer or count change.
REQ-015 read_pointer SHALL increment modulo DEPTH on each pop.
REQ-016 Both pointers SHALL wrap from DEPTH-1 to 0 with no other side effect.

Reset
REQ-017 While reset is 1 at a rising edge, the following SHALL be set to 0:
- wp, read_pointer, count, the priority bit, load_en, opcode, operand_a, operand_b.
- Resulting flags: empty=1, full=0, req_ready=0 during the reset cycle.
REQ-018 Reset SHALL override any simultaneous accept, write or pop, and SHALL discard a pending load_en write.

Structure
REQ-019 opcode_t, operand_t, address_t and instruction_t SHALL come from the shared instr_register_pkg; the package SHALL gain the DEPTH constant.
REQ-020 Round-robin arbitration SHALL live in sub-module instr_rr_arbiter with these ports:
- clk, reset, req[1:0], en, gnt[1:0].
- The instr_reg_ctrl top SHALL hold the pointers, count and output registers.

Verification
REQ-021 Reset, then requester 0 sends opcode ADD with A=5, B=3:
- Expected: req_ready=2'b01; load_en=1 one cycle later with write_pointer=0.
- Expected after that: count=1, rd_ready=1, read_pointer=0.
REQ-022 Both requesters valid for 4 cycles:
- Expected grants: 0,1,0,1; write_pointer 0,1,2,3.
- Expected final count=4.
REQ-023 Fill 32 entries from requester 1 with no pops:
- Expected: full=1 and req_ready=0 on the cycle the 32nd load_en is high; count=32 after it.
- Then 1 pop -> full=0 and a grant resumes.
REQ-024 Steady state at count=5, with a write and a pop in the same cycle:
- Expected: count stays 5; both pointers advance by 1.
- With read_pointer=31, expected read_pointer wraps to 0.
REQ-025 rd_valid=1 while empty:
- Expected: read_pointer, count and empty unchanged.
REQ-026 Assert reset on the cycle load_en=1:
- Expected: the next cycle has load_en=0, count=0, both pointers 0, priority back to requester 0.
